// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 slave fronting an internal byte array.
// Decodes a one-byte command (0x03 READ, 0x02 WRITE) followed by a 24-bit
// MSB-first address. It then streams bytes out on miso, or stores bytes
// arriving on mosi. The address wraps inside the array.
//
// Optional feature macro: SPI_MEM_RESPONDER_WRITE_EN
//   defined   - command 0x02 is accepted and the WRITE state is active
//   undefined - 0x02 is treated as unknown; the array is a read-only ROM
//               that can only be written through the backdoor
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, mosi, cs    SPI pins from the master (asynchronous to clk)
//   miso              serial read data, 0 outside READ
//   busy              synchronized cs low, delayed by two clk cycles
//   load_en/addr/data backdoor write port (wins over an SPI write to the
//                     same address in the same cycle)
//   peek_data         combinational mem[load_addr]
module spi_mem_responder #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          mosi,
    input  logic          cs,
    output logic          miso,
    output logic          busy,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic [7:0]    peek_data
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

    logic [7:0]    mem [DEPTH];

    logic [2:0]    sclk_sync;   // [0],[1] synchronizer, [2] previous sample
    logic [2:0]    cs_sync;
    logic [1:0]    mosi_sync;
    logic          busy_p;

    state_t        state, state_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [7:0]    rx_sr, rx_nxt;
    logic [7:0]    tx_sr, tx_nxt;

    logic          sclk_s, sclk_rise, sclk_fall;
    logic          cs_s, cs_fall, mosi_s;
    logic [7:0]    rx_shift;
    logic [AW-1:0] addr_inc;

`ifdef SPI_MEM_RESPONDER_WRITE_EN
    logic          is_wr, is_wr_nxt;
    logic          spi_we;
`endif

    assign sclk_s    = sclk_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_s      = cs_sync[1];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign mosi_s    = mosi_sync[1];
    assign rx_shift  = {rx_sr[6:0], mosi_s};
    assign addr_inc  = addr + {{(AW-1){1'b0}}, 1'b1};

    assign miso      = (state == READ) ? tx_sr[7] : 1'b0;
    assign peek_data = mem[load_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            busy_p    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
            busy_p    <= ~cs_s;
            busy      <= busy_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            addr    <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
`ifdef SPI_MEM_RESPONDER_WRITE_EN
            is_wr   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            addr    <= addr_nxt;
            rx_sr   <= rx_nxt;
            tx_sr   <= tx_nxt;
`ifdef SPI_MEM_RESPONDER_WRITE_EN
            is_wr   <= is_wr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        addr_nxt    = addr;
        rx_nxt      = rx_sr;
        tx_nxt      = tx_sr;
`ifdef SPI_MEM_RESPONDER_WRITE_EN
        is_wr_nxt   = is_wr;
        spi_we      = 1'b0;
`endif
        if (cs_s) begin
            // Deselect aborts everything, including a partial write byte.
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            tx_nxt      = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt   = CMD;
                        bit_cnt_nxt = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_nxt = rx_shift;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_nxt = '0;
                            if (rx_shift == 8'h03) begin
                                state_nxt = ADDR;
`ifdef SPI_MEM_RESPONDER_WRITE_EN
                                is_wr_nxt = 1'b0;
                            end else if (rx_shift == 8'h02) begin
                                state_nxt = ADDR;
                                is_wr_nxt = 1'b1;
`endif
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end
                ADDR: begin
                    // Only the low AW bits survive the 24-bit shift.
                    if (sclk_rise) begin
                        addr_nxt = {addr[AW-2:0], mosi_s};
                        if (bit_cnt == 5'd23) begin
                            bit_cnt_nxt = '0;
`ifdef SPI_MEM_RESPONDER_WRITE_EN
                            state_nxt   = is_wr ? WRITE : READ;
`else
                            state_nxt   = READ;
`endif
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end
                READ: begin
                    // bit_cnt counts bits already presented; 0 means no
                    // byte loaded yet, 8 means the next fall starts a new byte.
                    if (sclk_fall) begin
                        if (bit_cnt == 5'd0) begin
                            tx_nxt      = mem[addr];
                            bit_cnt_nxt = 5'd1;
                        end else if (bit_cnt == 5'd8) begin
                            tx_nxt      = mem[addr_inc];
                            addr_nxt    = addr_inc;
                            bit_cnt_nxt = 5'd1;
                        end else begin
                            tx_nxt      = {tx_sr[6:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end
`ifdef SPI_MEM_RESPONDER_WRITE_EN
                WRITE: begin
                    if (sclk_rise) begin
                        rx_nxt = rx_shift;
                        if (bit_cnt == 5'd7) begin
                            spi_we      = 1'b1;
                            addr_nxt    = addr_inc;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                        end
                    end
                end
`endif
                IGNORE: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Array is not reset. The backdoor write is last so it wins a collision.
    always_ff @(posedge clk) begin
`ifdef SPI_MEM_RESPONDER_WRITE_EN
        if (spi_we)
            mem[addr] <= rx_shift;
`endif
        if (load_en)
            mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: the SPI master is modelled with
// sclk at roughly clk/9 and 4+ clk setup/hold around chip select.
module tb_spi_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs = 1'b1;
    logic       miso;
    logic       busy;
    logic       load_en = 1'b0;
    logic [5:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic [7:0] peek_data;

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [7:0] got [4];

    spi_mem_responder #(.DEPTH(64), .AW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .miso      (miso),
        .busy      (busy),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .peek_data (peek_data)
    );

    always #5 clk = ~clk;

    task automatic bd_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic peek(input logic [5:0] a, output logic [7:0] d);
        load_addr = a;
        #1;
        d = peek_data;
    endtask

    // One SPI bit; miso is sampled at the pin rise. With bd set, a backdoor
    // write is issued in the same clk cycle the DUT acts on this rise.
    task automatic spi_bit(input logic b, input logic bd, input logic [5:0] ba,
                           input logic [7:0] bv, output logic r);
        mosi = b;
        @(negedge clk);
        sclk = 1'b1;
        r = miso;
        if (bd) begin
            @(negedge clk);
            @(negedge clk);
            load_en = 1'b1; load_addr = ba; load_data = bv;
            @(negedge clk);
            load_en = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--)
            spi_bit(tx[i], 1'b0, 6'd0, 8'd0, rx[i]);
    endtask

    task automatic spi_begin();
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] d;
        spi_byte(cmd, d);
        spi_byte(a[23:16], d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
    endtask

    task automatic spi_read4(input logic [23:0] a);
        logic [7:0] d;
        spi_begin();
        spi_cmd_addr(8'h03, a);
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, d);
            got[k] = d;
        end
        spi_end();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (miso !== 1'b0) begin
            bad++; $display("FAIL reset_miso: got %b expected 0", miso);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < 64; i++)
            bd_write(6'(i), 8'(i) ^ 8'h5A);
        bd_write(6'd0, 8'h13);
        bd_write(6'd1, 8'h05);
        bd_write(6'd2, 8'h10);
        bd_write(6'd3, 8'h00);
        peek(6'd2, d);
        total++;
        if (d !== 8'h10) begin
            bad++; $display("FAIL peek_addr2: got %h expected 10", d);
        end
    endtask

    task automatic test_read_basic();
        logic [7:0] exp [4];
        logic [7:0] d;
        exp = '{8'h13, 8'h05, 8'h10, 8'h00};
        spi_begin();
        spi_cmd_addr(8'h03, 24'h000000);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_active: got %b expected 1", busy);
        end
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'h00, d);
            got[k] = d;
        end
        spi_end();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got[k] !== exp[k]) begin
                bad++; $display("FAIL read_basic[%0d]: got %h expected %h", k, got[k], exp[k]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_read_wrap();
        logic [7:0] exp [4];
        exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        bd_write(6'd62, 8'hAA);
        bd_write(6'd63, 8'hBB);
        bd_write(6'd0, 8'hCC);
        bd_write(6'd1, 8'hDD);
        spi_read4(24'h00003E);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got[k] !== exp[k]) begin
                bad++; $display("FAIL read_wrap[%0d]: got %h expected %h", k, got[k], exp[k]);
            end
        end
    endtask

    task automatic test_upper_addr();
        spi_read4(24'hABCD02);
        total++;
        if (got[0] !== 8'h10) begin
            bad++; $display("FAIL upper_addr: got %h expected 10", got[0]);
        end
    endtask

    task automatic test_write();
        logic [7:0] d, acc, e16, e17, e18;
        logic r;
        acc = '0;
        spi_begin();
        spi_cmd_addr(8'h02, 24'h000010);
        spi_byte(8'hDE, d); acc |= d;
        spi_byte(8'hAD, d); acc |= d;
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b1, 1'b0, 6'd0, 8'd0, r);
            acc[0] = acc[0] | r;
        end
        spi_end();
`ifdef SPI_MEM_RESPONDER_WRITE_EN
        e16 = 8'hDE; e17 = 8'hAD;
`else
        e16 = 8'h10 ^ 8'h5A; e17 = 8'h11 ^ 8'h5A;
`endif
        e18 = 8'h12 ^ 8'h5A;
        total++;
        if (acc !== 8'h00) begin
            bad++; $display("FAIL write_miso: got %h expected 00", acc);
        end
        peek(6'd16, d);
        total++;
        if (d !== e16) begin
            bad++; $display("FAIL write_mem16: got %h expected %h", d, e16);
        end
        peek(6'd17, d);
        total++;
        if (d !== e17) begin
            bad++; $display("FAIL write_mem17: got %h expected %h", d, e17);
        end
        peek(6'd18, d);
        total++;
        if (d !== e18) begin
            bad++; $display("FAIL write_partial18: got %h expected %h", d, e18);
        end
    endtask

`ifdef SPI_MEM_RESPONDER_WRITE_EN
    task automatic test_collision();
        logic [7:0] d, tx;
        logic r;
        spi_begin();
        spi_cmd_addr(8'h02, 24'h000020);
        tx = 8'h11;
        for (int i = 7; i >= 0; i--)
            spi_bit(tx[i], i == 0, 6'd32, 8'h77, r);
        spi_end();
        spi_begin();
        spi_cmd_addr(8'h02, 24'h000021);
        tx = 8'h22;
        for (int i = 7; i >= 0; i--)
            spi_bit(tx[i], i == 0, 6'd48, 8'h44, r);
        spi_end();
        peek(6'd32, d);
        total++;
        if (d !== 8'h77) begin
            bad++; $display("FAIL collide_same: got %h expected 77", d);
        end
        peek(6'd33, d);
        total++;
        if (d !== 8'h22) begin
            bad++; $display("FAIL collide_spi: got %h expected 22", d);
        end
        peek(6'd48, d);
        total++;
        if (d !== 8'h44) begin
            bad++; $display("FAIL collide_bd: got %h expected 44", d);
        end
    endtask
`endif

    task automatic test_ignore();
        logic [7:0] d, acc;
        acc = '0;
        spi_begin();
        spi_byte(8'h9F, d);
        spi_byte(8'hA5, d); acc |= d;
        spi_byte(8'hFF, d); acc |= d;
        spi_end();
        total++;
        if (acc !== 8'h00) begin
            bad++; $display("FAIL ignore_miso: got %h expected 00", acc);
        end
        spi_read4(24'h000000);
        total++;
        if (got[0] !== 8'hCC) begin
            bad++; $display("FAIL ignore_then_read0: got %h expected cc", got[0]);
        end
        total++;
        if (got[1] !== 8'hDD) begin
            bad++; $display("FAIL ignore_then_read1: got %h expected dd", got[1]);
        end
    endtask

    task automatic test_cs_abort();
        logic [7:0] d;
        logic r;
        spi_begin();
        spi_byte(8'h03, d);
        for (int i = 0; i < 12; i++)
            spi_bit(1'b1, 1'b0, 6'd0, 8'd0, r);
        spi_end();
        spi_read4(24'h000001);
        total++;
        if (got[0] !== 8'hDD) begin
            bad++; $display("FAIL abort_then_read: got %h expected dd", got[0]);
        end
        total++;
        if (got[1] !== 8'h10) begin
            bad++; $display("FAIL abort_then_read_next: got %h expected 10", got[1]);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_wrap();
        test_upper_addr();
        test_write();
`ifdef SPI_MEM_RESPONDER_WRITE_EN
        test_collision();
`endif
        test_ignore();
        test_cs_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
